enc_step_sequencer: RTL

Sequences a chain of matrix-encoder step units (column parity first, then further per-slice steps) over a 64-line x 25-bit state.
- Owns two ping-pong state buffers; each step reads its source buffer and writes the other.
- Runs a host-programmed number of rounds of NUM_STEPS steps, using a start/done handshake per step.
- Sits between the host loader/readout and the step units; muxes the single shared buffer port to whichever step is active.

---
 rtl/enc_step_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/enc_step_sequencer.sv
// rtl/enc_step_sequencer.sv - ping-pong state buffer sequencer for a chain of encoder step units
// Optional WAIT watchdog enabled by defining SEQ_TIMEOUT_EN.
module enc_step_sequencer #(
    parameter int NUM_STEPS = 3,
    parameter int ROUND_W   = 5,
    parameter int TIMEOUT   = 4096,
    localparam int SW       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [ROUND_W-1:0]       i_num_rounds,
    input  logic                     i_load_en,
    input  logic [5:0]               i_load_addr,
    input  logic [24:0]              i_load_data,
    input  logic [5:0]               i_rd_addr,
    output logic [24:0]              o_rd_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [ROUND_W-1:0]       o_round_idx,
    output logic [SW-1:0]            o_step_idx,
    output logic [NUM_STEPS-1:0]     o_step_start,
    input  logic [NUM_STEPS-1:0]     i_step_done,
    input  logic [NUM_STEPS*6-1:0]   i_step_addr,
    output logic [24:0]              o_step_line,
    input  logic [NUM_STEPS-1:0]     i_step_wr_en,
    input  logic [NUM_STEPS*25-1:0]  i_step_wr_val
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SWAP,
        S_FINISH
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [24:0]          r_buf0 [0:63];
    logic [24:0]          r_buf1 [0:63];
    logic                 r_src_sel;
    logic [6:0]           r_wr_ptr;
    logic [ROUND_W-1:0]   r_rounds;
    logic [ROUND_W-1:0]   r_round_idx;
    logic [SW-1:0]        r_step_idx;
    logic                 r_err;

    logic [5:0]           w_act_addr;
    logic [24:0]          w_act_val;
    logic                 w_act_wr;
    logic                 w_act_done;
    logic                 w_wr_ok;
    logic                 w_wr_drop;
    logic [6:0]           w_ptr_inc;
    logic                 w_last_step;
    logic [ROUND_W-1:0]   w_round_inc;
    logic                 w_timeout;

    // Only the active step's strobes reach the buffer; all others are masked here.
    always_comb begin
        w_act_addr = 6'd0;
        w_act_val  = 25'd0;
        w_act_wr   = 1'b0;
        w_act_done = 1'b0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            if (r_step_idx == SW'(k)) begin
                w_act_addr = i_step_addr[k*6 +: 6];
                w_act_val  = i_step_wr_val[k*25 +: 25];
                w_act_wr   = i_step_wr_en[k];
                w_act_done = i_step_done[k];
            end
        end
    end

    assign w_wr_ok     = (r_state == S_WAIT) && w_act_wr && (r_wr_ptr != 7'd64);
    assign w_wr_drop   = (r_state == S_WAIT) && w_act_wr && (r_wr_ptr == 7'd64);
    assign w_ptr_inc   = r_wr_ptr + 7'(w_wr_ok);
    assign w_last_step = (r_step_idx == SW'(NUM_STEPS - 1));
    assign w_round_inc = r_round_idx + ROUND_W'(1);

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !w_act_done && (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = (i_num_rounds == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_act_done)     w_state_nxt = S_SWAP;
                else if (w_timeout) w_state_nxt = S_FINISH;
            end
            S_SWAP:   w_state_nxt = (w_last_step && (w_round_inc == r_rounds)) ? S_FINISH : S_ISSUE;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_src_sel   <= 1'b0;
            r_wr_ptr    <= 7'd0;
            r_rounds    <= '0;
            r_round_idx <= '0;
            r_step_idx  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rounds    <= i_num_rounds;
                        r_err       <= 1'b0;
                        r_src_sel   <= 1'b0;
                        r_round_idx <= '0;
                        r_step_idx  <= '0;
                    end
                end
                S_ISSUE: r_wr_ptr <= 7'd0;
                S_WAIT: begin
                    r_wr_ptr <= w_ptr_inc;
                    // A short step is flagged but the sequence still advances.
                    if (w_wr_drop || w_timeout || (w_act_done && (w_ptr_inc != 7'd64))) begin
                        r_err <= 1'b1;
                    end
                end
                S_SWAP: begin
                    r_src_sel <= ~r_src_sel;
                    if (w_last_step) begin
                        r_step_idx  <= '0;
                        r_round_idx <= w_round_inc;
                    end else begin
                        r_step_idx  <= r_step_idx + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if ((r_state == S_IDLE) && i_load_en) begin
            r_buf0[i_load_addr] <= i_load_data;
        end
        if (w_wr_ok) begin
            if (r_src_sel) r_buf0[r_wr_ptr[5:0]] <= w_act_val;
            else           r_buf1[r_wr_ptr[5:0]] <= w_act_val;
        end
    end

    assign o_rd_data    = r_src_sel ? r_buf1[i_rd_addr] : r_buf0[i_rd_addr];
    assign o_step_line  = r_src_sel ? r_buf1[w_act_addr] : r_buf0[w_act_addr];
    assign o_busy       = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_SWAP);
    assign o_done       = (r_state == S_FINISH);
    assign o_err        = r_err;
    assign o_round_idx  = r_round_idx;
    assign o_step_idx   = r_step_idx;
    assign o_step_start = (r_state == S_ISSUE) ? (NUM_STEPS'(1) << r_step_idx) : '0;

endmodule
